// File: rtl/seq_tx_1011.sv
// Serial framer for the 1011 sync detector: sends preamble 1011, then the payload
// MSB-first, one line bit per bit_en strobe. A 0 is stuffed whenever the next 1
// would complete a 1011 anywhere other than the end of the preamble.
module seq_tx_1011 #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_en,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              out_bit,
    output logic              busy,
    output logic              sync_pulse,
    output logic              stuff_pulse,
    output logic              frame_done
);

    localparam int unsigned     CntW     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CntW-1:0] LastIdx  = CntW'(DATA_W - 1);
    localparam logic [3:0]      Preamble = 4'b1011;

    typedef enum logic [1:0] {StIdle, StPre, StData} state_e;

    state_e            state_q;
    logic [2:0]        hist_q;      // last three line bits, newest in bit 0
    logic [1:0]        pre_cnt_q;
    logic [CntW-1:0]   data_cnt_q;
    logic [DATA_W-1:0] shifter_q;

    logic cand_bit;
    logic last_pre;
    logic do_stuff;

    // Candidate bit for the current slot and the stuffing decision.
    always_comb begin
        cand_bit = 1'b0;
        case (state_q)
            StPre:   cand_bit = Preamble[2'd3 - pre_cnt_q];
            StData:  cand_bit = shifter_q[DATA_W-1];
            default: cand_bit = 1'b0;
        endcase
        last_pre = (state_q == StPre) && (pre_cnt_q == 2'd3);
        // Line ending in 101 plus a 1 would form 1011; only the preamble end may do that.
        do_stuff = bit_en && (state_q != StIdle) && (hist_q == 3'b101) && cand_bit && !last_pre;
    end

    assign tx_ready = (state_q == StIdle) && !reset;
    assign busy     = (state_q != StIdle);

    // Framing FSM with registered line bit and pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            hist_q      <= 3'b000;
            pre_cnt_q   <= 2'd0;
            data_cnt_q  <= '0;
            shifter_q   <= '0;
            out_bit     <= 1'b0;
            sync_pulse  <= 1'b0;
            stuff_pulse <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            sync_pulse  <= 1'b0;
            stuff_pulse <= 1'b0;
            frame_done  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bit_en) begin
                        out_bit <= 1'b0;
                        hist_q  <= {hist_q[1:0], 1'b0};
                    end
                    // Accept does not need bit_en; the idle 0 above still goes out.
                    if (tx_valid && tx_ready) begin
                        shifter_q <= tx_data;
                        pre_cnt_q <= 2'd0;
                        state_q   <= StPre;
                    end
                end
                StPre, StData: begin
                    if (do_stuff) begin
                        // Counters and shifter hold so the candidate is retried.
                        out_bit     <= 1'b0;
                        hist_q      <= {hist_q[1:0], 1'b0};
                        stuff_pulse <= 1'b1;
                    end else if (bit_en) begin
                        out_bit <= cand_bit;
                        hist_q  <= {hist_q[1:0], cand_bit};
                        if (state_q == StPre) begin
                            if (last_pre) begin
                                sync_pulse <= 1'b1;
                                data_cnt_q <= '0;
                                state_q    <= StData;
                            end else begin
                                pre_cnt_q <= pre_cnt_q + 2'd1;
                            end
                        end else begin
                            shifter_q <= shifter_q << 1;
                            if (data_cnt_q == LastIdx) begin
                                frame_done <= 1'b1;
                                state_q    <= StIdle;
                            end else begin
                                data_cnt_q <= data_cnt_q + CntW'(1);
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/seq_tx_1011.md
Name: seq_tx_1011

Overview:
- Serial framer/transmitter feeding the 1011 sequence detector on the single-bit serial line.
- Accepts a parallel payload word through a valid/ready handshake.
- Emits the sync pattern 1011, then the payload MSB-first, one bit per bit_en strobe.
- Inserts stuffed 0 bits so that 1011 appears on the line exactly once per frame, ending on the final preamble bit.

Parameters:
DATA_W, 8, payload width in bits (>=1).

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  reset, synchronous, active-high
bit_en  input  1  line bit strobe; one line bit emitted per cycle with bit_en=1
tx_data  input  DATA_W  payload word
tx_valid  input  1  payload offered
tx_ready  output  1  block can accept payload
out_bit  output  1  serial line (registered)
busy  output  1  frame in progress (state != IDLE)
sync_pulse  output  1  1-cycle pulse when the 4th preamble bit is driven
stuff_pulse  output  1  1-cycle pulse when a stuffed 0 is driven
frame_done  output  1  1-cycle pulse when the last payload bit is driven

Behaviour:
- Reset values: out_bit=0, busy=0, sync_pulse=0, stuff_pulse=0, frame_done=0, state=IDLE, history=000, shifter=0.
- tx_ready = (state==IDLE) && !reset.
- Reset mid-frame aborts the frame and discards the payload; the next accept restarts with the preamble.
- History: a 3-bit register holding the last three bits driven on out_bit, including idle and stuffed bits. It updates only on bit_en cycles.
- State IDLE:
  - Every bit_en cycle drives out_bit<=0.
  - tx_valid&&tx_ready loads the shifter with tx_data, clears the preamble counter, and moves to PRE. This happens regardless of bit_en.
  - If bit_en is also high in the accept cycle, that cycle still drives the idle 0.
- State PRE: 4 line slots sending 1,0,1,1 (counter 0..3, advancing only on non-stuff bit_en cycles).
  - Driving bit 3 asserts sync_pulse and moves to DATA with the payload counter cleared.
- State DATA: sends shifter MSB-first (DATA_W non-stuffed slots).
  - Driving the last payload bit asserts frame_done and returns to IDLE.
- Stuff rule: on any bit_en cycle in PRE or DATA where history==101, the candidate bit is 1, and the candidate is not preamble bit 3:
  - Drive 0 instead and assert stuff_pulse.
  - Hold the candidate bit and counters; the candidate is retried on the next bit_en.
  - The rule guarantees no 1011 on the line other than the preamble's end, including across back-to-back frames.
- bit_en=0 cycles: out_bit, history, counters and the shifter all hold; pulses are 0.
- Pulses are registered and coincide with the clock edge on which out_bit takes the corresponding value.
- Latency: out_bit reflects a slot on the clock edge ending that bit_en cycle.
- tx_valid while busy is ignored (tx_ready=0). tx_data need only be stable in the accept cycle.
- Frame length on the line: 4+DATA_W+(number of stuffs) bit_en slots.

Test Plan:
- Reset, bit_en=1 always, send 0x00 → after the accept-cycle idle 0, line = 1011 00000000 (12 slots); sync_pulse once on slot 4; no stuff_pulse; frame_done on slot 12; then idle 0s.
- Send 0xB0 → line = 1011 1 0 1 [0] 1 0000 (13 slots); stuff_pulse on slot 8; a 1011 detector on out_bit fires once only.
- Send 0xFF → line = 1011 11111111, no stuffing; detector fires once.
- Send 0xAD → line = 1011 1 0 1 0 1 [0] 1 0 1 (13 slots), one stuff_pulse. Next: hold tx_valid with 0x00 and drive bit_en=0 on the cycle after frame_done → no idle bit; line continues [0] 1011 00000000 with stuff_pulse on the first preamble slot.
- bit_en toggling 1/0 every cycle with 0x00 → same 12-bit line sequence, each bit held 2 cycles; busy stays high throughout the frame.
- Assert reset in the middle of the DATA phase of 0xB0 → next cycle out_bit=0, busy=0, tx_ready=1 after release; a new send of 0xFF produces a clean 1011 11111111.
